// File: rtl/biquad_cascade_tdm.sv
// -----------------------------------------------------------------------------
// biquad_cascade_tdm
// Multi-channel cascaded Direct Form I biquad IIR filter. A single
// time-multiplexed multiply-accumulate serves NUM_SECTIONS sections for each of
// NUM_CHANNELS channels. One accepted sample takes 6*NUM_SECTIONS+1 cycles:
// five MAC cycles plus one write-back cycle per section, then one output cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   coef_wr_en/addr/data  write into the shadow coefficient bank
//                         (addr = 5*section + {b0,b1,b2,a1,a2})
//   coef_commit           copy shadow bank to active bank at next idle cycle
//   clear_state           zero all history and sat at next idle cycle
//   in, in_channel        input sample and its channel
//   in_valid / in_ready   input handshake (in_ready high only when idle)
//   out, out_channel      filtered sample of the last section (registered)
//   out_valid             one-cycle output strobe
//   sat                   sticky: a section result was clamped
// -----------------------------------------------------------------------------
module biquad_cascade_tdm #(
  parameter int SAMPLE_WIDTH   = 18,
  parameter int COEF_WIDTH     = 30,
  parameter int COEF_INT_WIDTH = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int NUM_SECTIONS   = 2
) (
  input  logic                                                       clk,
  input  logic                                                       reset_n,
  input  logic                                                       coef_wr_en,
  input  logic [$clog2(5*NUM_SECTIONS)-1:0]                          coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]                               coef_wr_data,
  input  logic                                                       coef_commit,
  input  logic                                                       clear_state,
  input  logic signed [SAMPLE_WIDTH-1:0]                             in,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] in_channel,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  output logic signed [SAMPLE_WIDTH-1:0]                             out,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_channel,
  output logic                                                       out_valid,
  output logic                                                       sat
);

  localparam int SW     = SAMPLE_WIDTH;
  localparam int CW     = COEF_WIDTH;
  localparam int F      = COEF_WIDTH - COEF_INT_WIDTH;
  localparam int AW     = $clog2(5*NUM_SECTIONS);
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int PROD_W = SW + CW;
  localparam int ACC_W  = SW + CW + 3;

  localparam logic signed [CW-1:0]    COEF_ONE = CW'(1) <<< F;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (F-1);
  localparam logic signed [ACC_W-1:0] S_MAX    = ACC_W'((2**(SW-1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN    = -(ACC_W'(2**(SW-1)));
  localparam logic [SEC_W-1:0]        SEC_LAST = SEC_W'(NUM_SECTIONS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WB, ST_OUT} state_t;

  state_t                   r_state;
  logic                     r_run;
  logic [2:0]               r_k;
  logic [SEC_W-1:0]         r_sec;
  logic [CH_W-1:0]          r_ch;
  logic signed [SW-1:0]     r_x;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_commit_pend;
  logic                     r_clear_pend;
  logic signed [SW-1:0]     r_out;
  logic [CH_W-1:0]          r_out_ch;
  logic                     r_out_valid;
  logic                     r_sat;

  logic                     w_idle;
  logic                     w_wb;
  logic                     w_commit_go;
  logic                     w_clear_go;
  logic                     w_accept;
  logic                     w_ch_ok;
  logic signed [SW-1:0]     w_op;
  logic signed [CW-1:0]     w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic signed [SW-1:0]     w_y;
  logic                     w_sat_hit;

  logic signed [CW-1:0]     w_coef_act [NUM_SECTIONS][5];
  logic signed [SW-1:0]     w_hist     [NUM_CHANNELS][NUM_SECTIONS][4];

  assign w_idle = (r_state == ST_IDLE);
  assign w_wb   = (r_state == ST_WB);

  // A pulse arriving while idle is applied at once; one arriving while busy
  // is remembered and applied on the first idle cycle.
  assign w_commit_go = w_idle && (coef_commit || r_commit_pend);
  assign w_clear_go  = w_idle && (clear_state || r_clear_pend);

  assign in_ready = r_run && w_idle && !coef_commit && !clear_state
                    && !r_commit_pend && !r_clear_pend;
  assign w_accept = in_valid && in_ready;
  assign w_ch_ok  = (int'(in_channel) < NUM_CHANNELS);

  // Coefficient banks: shadow written at any time, active copied on commit.
  // Both reset to passthrough (b0 = 1.0, rest 0).
  for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
    for (genvar gk = 0; gk < 5; gk++) begin : g_coef
      localparam logic signed [CW-1:0] RST_VAL = (gk == 0) ? COEF_ONE : '0;
      logic signed [CW-1:0] r_shadow;
      logic signed [CW-1:0] r_active;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_shadow <= RST_VAL;
          r_active <= RST_VAL;
        end else begin
          if (coef_wr_en && (coef_wr_addr == AW'(5*gi + gk))) begin
            r_shadow <= coef_wr_data;
          end
          if (w_commit_go) begin
            r_active <= r_shadow;
          end
        end
      end
      assign w_coef_act[gi][gk] = r_active;
    end
  end

  // History per (channel, section): x1, x2, y1, y2. Kept in flops because
  // reset and clear_state must zero every word in a single cycle.
  for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_ch
    for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_hist
      logic                 w_sel;
      logic signed [SW-1:0] r_x1;
      logic signed [SW-1:0] r_x2;
      logic signed [SW-1:0] r_y1;
      logic signed [SW-1:0] r_y2;
      assign w_sel = (r_ch == CH_W'(gc)) && (r_sec == SEC_W'(gi));
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_x1 <= '0;
          r_x2 <= '0;
          r_y1 <= '0;
          r_y2 <= '0;
        end else if (w_clear_go) begin
          r_x1 <= '0;
          r_x2 <= '0;
          r_y1 <= '0;
          r_y2 <= '0;
        end else if (w_wb && w_sel) begin
          r_x2 <= r_x1;
          r_x1 <= r_x;
          r_y2 <= r_y1;
          r_y1 <= w_y;
        end
      end
      assign w_hist[gc][gi][0] = r_x1;
      assign w_hist[gc][gi][1] = r_x2;
      assign w_hist[gc][gi][2] = r_y1;
      assign w_hist[gc][gi][3] = r_y2;
    end
  end

  // MAC operand for step k: x, x1, x2, y1, y2 against b0, b1, b2, a1, a2.
  always_comb begin
    w_op = r_x;
    case (r_k)
      3'd1:    w_op = w_hist[r_ch][r_sec][0];
      3'd2:    w_op = w_hist[r_ch][r_sec][1];
      3'd3:    w_op = w_hist[r_ch][r_sec][2];
      3'd4:    w_op = w_hist[r_ch][r_sec][3];
      default: w_op = r_x;
    endcase
  end

  assign w_coef     = w_coef_act[r_sec][r_k];
  assign w_prod     = w_op * w_coef;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Round half up, drop the fraction, clamp to the sample range.
  assign w_rnd = r_acc + RND_HALF;
  assign w_shr = w_rnd >>> F;

  always_comb begin
    w_sat_hit = 1'b0;
    w_y       = w_shr[SW-1:0];
    if (w_shr > S_MAX) begin
      w_y       = S_MAX[SW-1:0];
      w_sat_hit = 1'b1;
    end else if (w_shr < S_MIN) begin
      w_y       = S_MIN[SW-1:0];
      w_sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_run         <= 1'b0;
      r_k           <= '0;
      r_sec         <= '0;
      r_ch          <= '0;
      r_x           <= '0;
      r_acc         <= '0;
      r_commit_pend <= 1'b0;
      r_clear_pend  <= 1'b0;
      r_out         <= '0;
      r_out_ch      <= '0;
      r_out_valid   <= 1'b0;
      r_sat         <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_out_valid <= 1'b0;

      if (w_commit_go)      r_commit_pend <= 1'b0;
      else if (coef_commit) r_commit_pend <= 1'b1;

      if (w_clear_go)       r_clear_pend <= 1'b0;
      else if (clear_state) r_clear_pend <= 1'b1;

      if (w_clear_go)             r_sat <= 1'b0;
      else if (w_wb && w_sat_hit) r_sat <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          // Out-of-range channels are accepted but otherwise ignored.
          if (w_accept && w_ch_ok) begin
            r_ch    <= in_channel;
            r_x     <= in;
            r_sec   <= '0;
            r_k     <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= ((r_k == 3'd0) ? '0 : r_acc) + w_prod_ext;
          if (r_k == 3'd4) begin
            r_state <= ST_WB;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        ST_WB: begin
          // This section's y becomes the next section's x.
          r_x <= w_y;
          r_k <= '0;
          if (r_sec == SEC_LAST) begin
            r_state <= ST_OUT;
          end else begin
            r_sec   <= r_sec + 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_OUT: begin
          r_out       <= r_x;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out         = r_out;
  assign out_channel = r_out_ch;
  assign out_valid   = r_out_valid;
  assign sat         = r_sat;

endmodule

// File: doc/biquad_cascade_tdm.md
# biquad_cascade_tdm

Multi-channel, multi-section cascaded biquad IIR filter. A single time-multiplexed multiply-accumulate unit serves NUM_SECTIONS Direct Form I sections for each of NUM_CHANNELS independent channels. It is the parametrised successor to the single-section fast biquad and sits in the audio/MPX path at the 38 kHz sample rate, clocked by mclk. Coefficients are shared by all channels and updated atomically through a shadow bank; filter history is kept per channel.

## Interface
- SAMPLE_WIDTH, 18: signed sample width for input, output and history.
- COEF_WIDTH, 30: signed coefficient width.
- COEF_INT_WIDTH, 4: integer bits, including sign. F = COEF_WIDTH-COEF_INT_WIDTH fractional bits; 1.0 = 2^F.
- NUM_CHANNELS, 2: independent channels (≥1).
- NUM_SECTIONS, 2: cascaded biquad sections (≥1).
- clk  in  1  clock (mclk domain).
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- coef_wr_en  in  1  write coef_wr_data into the shadow bank.
- coef_wr_addr  in  $clog2(5*NUM_SECTIONS)  address = 5*section + k, with k = 0..4 selecting b0, b1, b2, a1, a2.
- coef_wr_data  in  COEF_WIDTH  signed coefficient.
- coef_commit  in  1  pulse; copy the shadow bank to the active bank at the next idle cycle.
- clear_state  in  1  pulse; zero all history at the next idle cycle.
- in  in  SAMPLE_WIDTH  signed input sample.
- in_channel  in  max(1,$clog2(NUM_CHANNELS))  channel of `in`.
- in_valid  in  1  input strobe.
- in_ready  out  1  block idle; a sample is accepted on in_valid && in_ready.
- out  out  SAMPLE_WIDTH  filtered sample (registered).
- out_channel  out  max(1,$clog2(NUM_CHANNELS))  channel of `out`.
- out_valid  out  1  one-cycle strobe.
- sat  out  1  sticky flag: a section result saturated. Cleared by clear_state or reset.

## Operation
- Per section: y = b0·x + b1·x1 + b2·x2 + a1·y1 + a2·y2. Feedback terms are added, so the denominator is 1 − a1·z⁻¹ − a2·z⁻².
- Each section's output is the next section's x. The out port carries the last section's y.
- FSM states: IDLE → MAC (5 cycles per section: b0, b1, b2, a1, a2) → WB (1 cycle per section) → next section's MAC, or OUT after the last section → IDLE.
- WB computes y = sat(round(acc)), then updates the section history: x2←x1, x1←x, y2←y1, y1←y.
- Accumulator width is SAMPLE_WIDTH+COEF_WIDTH+3 bits; there is no overflow inside the accumulator.
- Rounding: add 2^(F−1), then arithmetic shift right by F (round half up).
- Saturation clamps to [−2^(SAMPLE_WIDTH−1), 2^(SAMPLE_WIDTH−1)−1] and sets sat.
- History storage holds 4 words per (channel, section), indexed by the latched channel. Other channels' history is never touched.
- in_channel ≥ NUM_CHANNELS: the sample is accepted, no state changes, and there is no out_valid.
- Active-bank reset value is passthrough for every section: b0 = 2^F, all other coefficients 0. The shadow bank resets to the same values.
- coef_commit while busy is held pending and applied in the first idle cycle. The in-flight sample completes with the old coefficients.
- clear_state while busy is handled the same way: held pending, and the in-flight sample uses the old history.
- Pending commit and pending clear apply in the same cycle if both are set.
- coef_wr_en is allowed at any time; it only affects the shadow bank.

## Timing
- Reset values: in_ready=0, out=0, out_channel=0, out_valid=0, sat=0. All history is 0.
- in_ready rises at the first clk edge after reset_n deasserts.
- in_ready is low in any cycle where clear_state or coef_commit is high, or where a clear or commit is pending. This is a combinational path from those inputs.
- Sample accepted at edge T: in_ready=0 from T until out_valid. out, out_channel and out_valid are valid at edge T+6·NUM_SECTIONS+1, which is 13 cycles for the defaults.
- in_ready returns high in the out_valid cycle. A back-to-back accept is therefore possible every 6·NUM_SECTIONS+1 cycles.
- Budget requirement: NUM_CHANNELS·(6·NUM_SECTIONS+1) ≤ mclk cycles per sample (128 at 38 kHz).
- in_valid while in_ready=0 is ignored (dropped). The source must hold off.
- reset_n asserted mid-sample: the in-flight result is discarded, no out_valid is produced, and all registers return to reset values immediately.

## Test plan
- Reset defaults (passthrough): in=1000 on ch0 → out=1000, out_channel=0, out_valid exactly 13 cycles after accept; in=−131072 → out=−131072.
- 50 µs pre-emphasis: section 0 loaded with b0=2.375·2^26, b1=−1.875·2^26, a1=0.5·2^26; section 1 passthrough; commit. Constant 1000 on ch0 → outputs 2375, 1688, 1344, 1172, …, converging to 1000.
- Channel isolation: interleave ch0 = constant 1000 and ch1 = 0 with the pre-emphasis coefficients → ch1 outputs all 0; ch0 sequence identical to the previous scenario. in_channel=3 with NUM_CHANNELS=2 → no out_valid.
- Saturation: b0=4.0·2^26, in=100000 → out=131071, sat=1; in=−100000 → out=−131072. clear_state → sat=0.
- Deferred commit/clear: write new coefficients and pulse coef_commit 4 cycles after accept → current output uses old coefficients, next sample uses new ones, and in_ready stays low for the apply cycle.
- Async reset mid-sample: drop reset_n 5 cycles after accept → no out_valid for that sample; afterwards history is zero and the coefficients are passthrough (in=500 → out=500).
